cpu_phase_sequencer: RTL and testbench
======================================

// Module: cpu_phase_sequencer
// PURPOSE
//  Multi-cycle control FSM for the RV32I core. Sequences FETCH/DECODE/EXECUTE/MEM/WB,
//  owns the memory request handshake, and issues single-cycle write enables
//  (ir_load, rd_we, pc_we, mem_we) in place of gated clocks.
//  Sits beside the per-format instruction decoders: they steer muxes, this block decides when state commits.
// PARAMETERS
//  MEM_TIMEOUT  255  max cycles mem_req may wait for mem_ready before TRAP (1..65535)
//  CNT_W        32   width of instret counter
// PORTS
//  CLK          in   1      core clock, all state updates on rising edge
//  RST          in   1      synchronous, active-high reset
//  run          in   1      1 = execute; 0 = park in IDLE at next instruction boundary
//  opcode       in   7      INSN[6:0] from the instruction register (valid from DECODE on)
//  mem_ready    in   1      memory completes current request this cycle
//  mem_req      out  1      memory request; held until mem_ready sampled high
//  mem_we       out  1      1 = write request (STORE), only valid with mem_req
//  addr_sel     out  1      0 = PC drives address, 1 = ALU result drives address
//  ir_load      out  1      load instruction register (= mem_req & mem_ready in FETCH)
//  rd_we        out  1      register-file write strobe, one cycle
//  pc_we        out  1      PC update strobe, one cycle
//  state        out  3      current FSM state (debug)
//  halted       out  1      sticky: SYSTEM opcode executed
//  trap         out  1      sticky: illegal opcode or memory timeout
//  trap_cause   out  2      00 none, 01 illegal opcode, 10 mem timeout
//  instret      out  CNT_W  retired-instruction count
// BEHAVIOUR
//  - Reset: state=IDLE; all strobes, mem_req, halted, trap 0; trap_cause=00; instret=0; wait counter=0.
//  - Outputs are Moore decodes of the state register, except ir_load (mem_req & mem_ready).
//  - IDLE -> FETCH when run=1; else stay.
//  - FETCH: mem_req=1, mem_we=0, addr_sel=0. mem_ready=1 -> ir_load=1, go DECODE; else stay.
//  - DECODE (1 cycle): classify opcode. SYSTEM 1110011 -> HALT; unknown -> TRAP(01); else EXECUTE.
//  - EXECUTE (1 cycle): LOAD 0000011 / STORE 0100011 -> MEM; all others -> WB.
//  - MEM: mem_req=1, addr_sel=1, mem_we=1 for STORE only. Leave on mem_ready=1 -> WB.
//  - WB (1 cycle): pc_we=1.
//      rd_we=1 for R, I-ALU, LOAD, JAL, JALR, LUI, AUIPC.
//      rd_we=0 for STORE, BRANCH, FENCE (0001111, executed as NOP).
//      instret+=1 (wraps modulo 2^CNT_W). Next: FETCH if run=1, else IDLE.
//  - Cycle counts (zero-wait memory): R/I/branch/jump = 4 cycles; LOAD/STORE = 5 cycles.
//  - Timeout: wait counter increments each FETCH/MEM cycle with mem_ready=0 and clears on state exit.
//    At count==MEM_TIMEOUT (without ready) -> TRAP(10). mem_ready in that same cycle wins; no trap.
//  - HALT, TRAP: mem_req=0, all strobes 0; absorbing until RST; run ignored.
//  - run dropped mid-instruction: current instruction completes through WB, then IDLE.
//  - RST mid-request: mem_req falls on the next edge; the memory must tolerate an abandoned request.
//  - Opcode is sampled in DECODE and held in an internal class register.
//    Later opcode changes do not alter EXECUTE/MEM/WB.
// STRUCTURE
//  - Shared header cpu_ctrl_defs.vh: state encodings (IDLE, FETCH, DECODE, EXECUTE, MEM, WB, HALT, TRAP),
//    RV32I opcode constants, trap_cause codes.
//  - One sub-module: opcode_class_decode (combinational opcode -> {is_load, is_store, writes_rd, is_system, illegal}).
//  - Top holds the state register, class register, wait counter and instret counter.
// TESTING
//  1. RST=1 for 2 cycles, run=0 -> state=IDLE, every output 0, instret=0; stays IDLE 10 cycles.
//  2. run=1, mem_ready=1, opcode=0110011 -> FETCH, DECODE, EXECUTE, WB.
//     ir_load at cycle 1, rd_we=pc_we=1 at cycle 4, instret=1.
//  3. opcode=0100011, mem_ready low 3 cycles in MEM -> mem_req=mem_we=addr_sel=1 held 4 cycles.
//     Then WB: rd_we=0, pc_we=1.
//  4. MEM_TIMEOUT=4, mem_ready=0 in FETCH -> TRAP after 4 wait cycles, trap=1, trap_cause=10.
//     Stays until RST. Repeat with ready on cycle 4 -> no trap.
//  5. opcode=1111111 -> TRAP cause 01, no rd_we/pc_we. opcode=1110011 -> halted=1, instret unchanged.
//  6. Drop run during EXECUTE of LOAD -> finishes MEM, WB (rd_we=1), then IDLE.
//     Assert RST in MEM -> IDLE next edge, mem_req=0.

Source files
------------

// File: rtl/cpu_phase_sequencer_pkg.sv
// Shared definitions for the RV32I multi-cycle phase sequencer: state encodings,
// base-ISA opcode constants, trap cause codes and the registered opcode class.
package cpu_phase_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_HALT    = 3'd6,
        ST_TRAP    = 3'd7
    } seq_state_t;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    localparam logic [1:0] CAUSE_NONE        = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL     = 2'b01;
    localparam logic [1:0] CAUSE_MEM_TIMEOUT = 2'b10;

    // Only the attributes still needed after DECODE are kept in the class register.
    typedef struct packed {
        logic is_load;
        logic is_store;
        logic writes_rd;
    } op_class_t;

    function automatic logic is_mem_state(seq_state_t s);
        return (s == ST_FETCH) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/cpu_phase_sequencer_opcode_class_decode.sv
// Combinational opcode classifier: maps INSN[6:0] to the handful of attributes
// the phase sequencer needs to pick its path through EXECUTE/MEM/WB.
module cpu_phase_sequencer_opcode_class_decode
    import cpu_phase_sequencer_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       is_load,
    output logic       is_store,
    output logic       writes_rd,
    output logic       is_system,
    output logic       illegal
);

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        writes_rd = 1'b0;
        is_system = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OP_LOAD: begin
                is_load   = 1'b1;
                writes_rd = 1'b1;
            end
            OP_STORE:                                               is_store  = 1'b1;
            OP_OP, OP_OP_IMM, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC:    writes_rd = 1'b1;
            // FENCE runs as a NOP: same path as a branch, no register write.
            OP_BRANCH, OP_MISC_MEM:                                 writes_rd = 1'b0;
            OP_SYSTEM:                                              is_system = 1'b1;
            default:                                                illegal   = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Multi-cycle control FSM for the RV32I core: sequences the instruction phases,
// owns the memory request handshake and issues one-cycle commit strobes.
module cpu_phase_sequencer
    import cpu_phase_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_load,
    output logic             rd_we,
    output logic             pc_we,
    output logic [2:0]       state,
    output logic             halted,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    localparam logic [15:0] WAIT_LIMIT = 16'(MEM_TIMEOUT);

    seq_state_t       state_q;
    op_class_t        class_q;
    logic [15:0]      wait_cnt;
    logic [1:0]       cause_q;
    logic [CNT_W-1:0] instret_q;

    logic dec_load;
    logic dec_store;
    logic dec_writes_rd;
    logic dec_system;
    logic dec_illegal;
    logic mem_phase;
    logic wait_expired;

    cpu_phase_sequencer_opcode_class_decode u_decode (
        .opcode    (opcode),
        .is_load   (dec_load),
        .is_store  (dec_store),
        .writes_rd (dec_writes_rd),
        .is_system (dec_system),
        .illegal   (dec_illegal)
    );

    // The current cycle is the MEM_TIMEOUT-th consecutive one without ready;
    // a ready in this same cycle still completes the request.
    assign mem_phase    = is_mem_state(state_q);
    assign wait_expired = mem_phase && !mem_ready && ((wait_cnt + 16'd1) == WAIT_LIMIT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            class_q   <= '0;
            wait_cnt  <= '0;
            cause_q   <= CAUSE_NONE;
            instret_q <= '0;
        end else begin
            if (mem_phase && !mem_ready && !wait_expired) begin
                wait_cnt <= wait_cnt + 16'd1;
            end else begin
                wait_cnt <= '0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (mem_ready) begin
                        state_q <= ST_DECODE;
                    end else if (wait_expired) begin
                        state_q <= ST_TRAP;
                        cause_q <= CAUSE_MEM_TIMEOUT;
                    end
                end
                ST_DECODE: begin
                    class_q <= '{is_load: dec_load, is_store: dec_store, writes_rd: dec_writes_rd};
                    if (dec_system) begin
                        state_q <= ST_HALT;
                    end else if (dec_illegal) begin
                        state_q <= ST_TRAP;
                        cause_q <= CAUSE_ILLEGAL;
                    end else begin
                        state_q <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    state_q <= (class_q.is_load || class_q.is_store) ? ST_MEM : ST_WB;
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        state_q <= ST_WB;
                    end else if (wait_expired) begin
                        state_q <= ST_TRAP;
                        cause_q <= CAUSE_MEM_TIMEOUT;
                    end
                end
                ST_WB: begin
                    instret_q <= instret_q + CNT_W'(1);
                    state_q   <= run ? ST_FETCH : ST_IDLE;
                end
                // HALT and TRAP only leave through reset.
                ST_HALT, ST_TRAP: begin
                    state_q <= state_q;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req    = mem_phase;
    assign mem_we     = (state_q == ST_MEM) && class_q.is_store;
    assign addr_sel   = (state_q == ST_MEM);
    assign ir_load    = (state_q == ST_FETCH) && mem_ready;
    assign rd_we      = (state_q == ST_WB) && class_q.writes_rd;
    assign pc_we      = (state_q == ST_WB);
    assign state      = state_q;
    assign halted     = (state_q == ST_HALT);
    assign trap       = (state_q == ST_TRAP);
    assign trap_cause = cause_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Self-checking bench for cpu_phase_sequencer: per-cycle scripts are generated from
// an instruction-level model of the phase rules and compared against the DUT outputs.
module tb_cpu_phase_sequencer;
    import cpu_phase_sequencer_pkg::*;

    localparam int TIMEOUT = 4;
    localparam int CW      = 32;

    logic          CLK = 1'b0;
    logic          RST;
    logic          run;
    logic [6:0]    opcode;
    logic          mem_ready;
    logic          mem_req;
    logic          mem_we;
    logic          addr_sel;
    logic          ir_load;
    logic          rd_we;
    logic          pc_we;
    logic [2:0]    state;
    logic          halted;
    logic          trap;
    logic [1:0]    trap_cause;
    logic [CW-1:0] instret;

    int            errors = 0;
    int            checks = 0;
    logic [CW-1:0] exp_instret;

    // Bit order: state[2:0], mem_req, mem_we, addr_sel, ir_load, rd_we, pc_we, halted, trap, trap_cause[1:0]
    logic [12:0]   obs;
    assign obs = {state, mem_req, mem_we, addr_sel, ir_load, rd_we, pc_we, halted, trap, trap_cause};

    typedef struct {
        logic [12:0] exp;
        logic        ready;
        logic        run_v;
        logic [6:0]  op;
        logic        rst;
        string       tag;
    } step_t;

    step_t script[$];

    logic [6:0] legal_ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                   7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111};

    cpu_phase_sequencer #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .run        (run),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .addr_sel   (addr_sel),
        .ir_load    (ir_load),
        .rd_we      (rd_we),
        .pc_we      (pc_we),
        .state      (state),
        .halted     (halted),
        .trap       (trap),
        .trap_cause (trap_cause),
        .instret    (instret)
    );

    always #5 CLK = ~CLK;

    function automatic logic [12:0] pack(input logic [2:0] st, input logic req, input logic we,
                                         input logic sel, input logic irl, input logic rdw,
                                         input logic pcw, input logic hlt, input logic trp,
                                         input logic [1:0] cause);
        return {st, req, we, sel, irl, rdw, pcw, hlt, trp, cause};
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom);
    endfunction

    function automatic logic [6:0] rnd_op();
        return 7'($urandom);
    endfunction

    function automatic void push_step(input logic [12:0] e, input logic rdy, input logic rn,
                                      input logic [6:0] op, input string tag, input logic rs = 1'b0);
        step_t s;
        s.exp   = e;
        s.ready = rdy;
        s.run_v = rn;
        s.op    = op;
        s.rst   = rs;
        s.tag   = tag;
        script.push_back(s);
    endfunction

    // Instruction-level model: fetch with fw wait cycles, then decode of op.
    function automatic void model_prefix(input logic [6:0] op, input int fw);
        for (int i = 0; i < fw; i++)
            push_step(pack(ST_FETCH, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00), 1'b0, rnd_bit(), rnd_op(), "fetch_wait");
        push_step(pack(ST_FETCH, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00), 1'b1, rnd_bit(), rnd_op(), "fetch_ready");
        push_step(pack(ST_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00), rnd_bit(), rnd_bit(), op, "decode");
    endfunction

    function automatic void model_instr(input logic [6:0] op, input int fw, input int mw, input logic run_after);
        logic ld;
        logic st;
        logic wr;
        ld = (op == 7'b0000011);
        st = (op == 7'b0100011);
        wr = op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        model_prefix(op, fw);
        push_step(pack(ST_EXECUTE, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00), rnd_bit(), rnd_bit(), rnd_op(), "execute");
        if (ld || st) begin
            for (int i = 0; i < mw; i++)
                push_step(pack(ST_MEM, 1, st, 1, 0, 0, 0, 0, 0, 2'b00), 1'b0, rnd_bit(), rnd_op(), "mem_wait");
            push_step(pack(ST_MEM, 1, st, 1, 0, 0, 0, 0, 0, 2'b00), 1'b1, rnd_bit(), rnd_op(), "mem_ready");
        end
        push_step(pack(ST_WB, 0, 0, 0, 0, wr, 1, 0, 0, 2'b00), rnd_bit(), run_after, rnd_op(), "writeback");
        exp_instret = exp_instret + 1;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST       = 1'b1;
        run       = 1'b0;
        mem_ready = 1'b0;
        opcode    = '0;
        tick();
        tick();
        RST         = 1'b0;
        exp_instret = '0;
        script.delete();
    endtask

    task automatic test_reset();
        step_t s;
        do_reset();
        #1;
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: observed=%b required=%b", obs, 13'd0);
        end
        checks++;
        if (instret !== '0) begin
            errors++;
            $display("[TB] FAIL reset_instret: observed=%0d required=0", instret);
        end
        for (int i = 0; i < 10; i++)
            push_step(pack(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00), rnd_bit(), 1'b0, rnd_op(), "idle_hold");
        while (script.size() > 0) begin
            s = script.pop_front();
            tick();
            RST = s.rst; mem_ready = s.ready; run = s.run_v; opcode = s.op;
            #1;
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("[TB] FAIL reset/%s: observed=%b required=%b", s.tag, obs, s.exp);
            end
        end
    endtask

    task automatic test_r_type_and_store();
        step_t s;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            run = 1'b1;
            if (pass == 0) model_instr(7'b0110011, 0, 0, 1'b0);
            else           model_instr(7'b0100011, 0, 3, 1'b0);
            push_step(pack(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00), 1'b0, 1'b0, rnd_op(), "park_idle");
            while (script.size() > 0) begin
                s = script.pop_front();
                tick();
                RST = s.rst; mem_ready = s.ready; run = s.run_v; opcode = s.op;
                #1;
                checks++;
                if (obs !== s.exp) begin
                    errors++;
                    $display("[TB] FAIL single_%0d/%s: observed=%b required=%b", pass, s.tag, obs, s.exp);
                end
            end
            checks++;
            if (instret !== exp_instret) begin
                errors++;
                $display("[TB] FAIL single_%0d/instret: observed=%0d required=%0d", pass, instret, exp_instret);
            end
        end
    endtask

    task automatic test_timeout();
        step_t s;
        for (int pass = 0; pass < 3; pass++) begin
            do_reset();
            run = 1'b1;
            if (pass == 0) begin
                for (int i = 0; i < TIMEOUT; i++)
                    push_step(pack(ST_FETCH, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00), 1'b0, rnd_bit(), rnd_op(), "fetch_wait");
            end else if (pass == 1) begin
                model_instr(7'b0110011, TIMEOUT - 1, 0, 1'b0);
                push_step(pack(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00), 1'b0, 1'b0, rnd_op(), "park_idle");
            end else begin
                model_prefix(7'b0000011, 0);
                push_step(pack(ST_EXECUTE, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00), 1'b0, 1'b1, rnd_op(), "execute");
                for (int i = 0; i < TIMEOUT; i++)
                    push_step(pack(ST_MEM, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00), 1'b0, rnd_bit(), rnd_op(), "mem_wait");
            end
            if (pass != 1)
                for (int i = 0; i < 5; i++)
                    push_step(pack(ST_TRAP, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10), rnd_bit(), rnd_bit(), rnd_op(), "trap_hold");
            while (script.size() > 0) begin
                s = script.pop_front();
                tick();
                RST = s.rst; mem_ready = s.ready; run = s.run_v; opcode = s.op;
                #1;
                checks++;
                if (obs !== s.exp) begin
                    errors++;
                    $display("[TB] FAIL timeout_%0d/%s: observed=%b required=%b", pass, s.tag, obs, s.exp);
                end
            end
            checks++;
            if (instret !== exp_instret) begin
                errors++;
                $display("[TB] FAIL timeout_%0d/instret: observed=%0d required=%0d", pass, instret, exp_instret);
            end
        end
    endtask

    task automatic test_illegal_and_halt();
        step_t s;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            run = 1'b1;
            if (pass == 0) begin
                model_prefix(7'b1111111, 1);
                for (int i = 0; i < 4; i++)
                    push_step(pack(ST_TRAP, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01), rnd_bit(), rnd_bit(), rnd_op(), "illegal_trap");
            end else begin
                model_instr(7'b0010011, 0, 0, 1'b1);
                model_prefix(7'b1110011, 0);
                for (int i = 0; i < 5; i++)
                    push_step(pack(ST_HALT, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00), rnd_bit(), rnd_bit(), rnd_op(), "halt_hold");
            end
            while (script.size() > 0) begin
                s = script.pop_front();
                tick();
                RST = s.rst; mem_ready = s.ready; run = s.run_v; opcode = s.op;
                #1;
                checks++;
                if (obs !== s.exp) begin
                    errors++;
                    $display("[TB] FAIL illegal_halt_%0d/%s: observed=%b required=%b", pass, s.tag, obs, s.exp);
                end
            end
            checks++;
            if (instret !== exp_instret) begin
                errors++;
                $display("[TB] FAIL illegal_halt_%0d/instret: observed=%0d required=%0d", pass, instret, exp_instret);
            end
        end
    endtask

    task automatic test_run_drop_and_reset();
        step_t s;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            run = 1'b1;
            if (pass == 0) begin
                model_prefix(7'b0000011, 0);
                push_step(pack(ST_EXECUTE, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00), 1'b0, 1'b0, rnd_op(), "execute_drop");
                push_step(pack(ST_MEM, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00), 1'b1, 1'b0, rnd_op(), "mem_ready");
                push_step(pack(ST_WB, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00), 1'b0, 1'b0, rnd_op(), "writeback");
                exp_instret = exp_instret + 1;
                for (int i = 0; i < 3; i++)
                    push_step(pack(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00), rnd_bit(), 1'b0, rnd_op(), "parked");
            end else begin
                model_instr(7'b0110011, 0, 0, 1'b1);
                model_prefix(7'b0000011, 1);
                push_step(pack(ST_EXECUTE, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00), 1'b0, 1'b1, rnd_op(), "execute");
                push_step(pack(ST_MEM, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00), 1'b0, 1'b1, rnd_op(), "mem_reset", 1'b1);
                push_step(pack(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00), 1'b0, 1'b0, rnd_op(), "after_reset");
                exp_instret = '0;
            end
            while (script.size() > 0) begin
                s = script.pop_front();
                tick();
                RST = s.rst; mem_ready = s.ready; run = s.run_v; opcode = s.op;
                #1;
                checks++;
                if (obs !== s.exp) begin
                    errors++;
                    $display("[TB] FAIL run_reset_%0d/%s: observed=%b required=%b", pass, s.tag, obs, s.exp);
                end
            end
            checks++;
            if (instret !== exp_instret) begin
                errors++;
                $display("[TB] FAIL run_reset_%0d/instret: observed=%0d required=%0d", pass, instret, exp_instret);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t      s;
        logic [6:0] op;
        logic       cont;
        int         idle_len;
        do_reset();
        run = 1'b1;
        for (int n = 0; n < 40; n++) begin
            op   = legal_ops[$urandom_range(0, 9)];
            cont = (n != 39) && ($urandom_range(0, 4) != 0);
            model_instr(op, $urandom_range(0, TIMEOUT - 1), $urandom_range(0, TIMEOUT - 1), cont);
            if (!cont && n != 39) begin
                idle_len = $urandom_range(1, 3);
                for (int i = 0; i < idle_len; i++)
                    push_step(pack(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00), rnd_bit(),
                              (i == idle_len - 1), rnd_op(), "idle_gap");
            end
        end
        push_step(pack(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00), 1'b0, 1'b0, rnd_op(), "park_idle");
        while (script.size() > 0) begin
            s = script.pop_front();
            tick();
            RST = s.rst; mem_ready = s.ready; run = s.run_v; opcode = s.op;
            #1;
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("[TB] FAIL stream/%s: observed=%b required=%b", s.tag, obs, s.exp);
            end
        end
        checks++;
        if (instret !== exp_instret) begin
            errors++;
            $display("[TB] FAIL stream/instret: observed=%0d required=%0d", instret, exp_instret);
        end
    endtask

    initial begin
        RST       = 1'b1;
        run       = 1'b0;
        mem_ready = 1'b0;
        opcode    = '0;
        test_reset();
        test_r_type_and_store();
        test_timeout();
        test_illegal_and_halt();
        test_run_drop_and_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
